stoch_signed_decode_mat: RTL and testbench

- Windowed decoder for a matrix of signed stochastic bitstreams, each carried as a (p, m) rail pair.
- Sits directly downstream of the signed stochastic matrix add/sub stages.
- Over a window of 2^WINDOW_LOG2 cycles it accumulates (p − m) per element.
- At window end it presents a signed two's-complement count per element, for deterministic readout or comparison.

---
 rtl/stoch_signed_decode_mat.sv | 165 ++++++++++++++++
 tb/tb_stoch_signed_decode_mat.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stoch_signed_decode_mat.sv
// ---------------------------------------------------------------------------
// stoch_signed_decode_mat
//
// Windowed decoder for a matrix of signed stochastic bitstreams. Each element
// arrives as a (p, m) rail pair. Over a window of N = 2**WINDOW_LOG2 cycles
// the block sums (p - m) per element. At the end of the window it publishes
// a signed two's-complement count per element, in the range -N..+N.
//
// Ports
//   CLK    : clock; all state changes happen on the rising edge
//   nRST   : asynchronous, active-low reset
//   start  : requests a new window; only looked at while idle
//   Y_p    : positive rail bit per element
//   Y_m    : negative rail bit per element
//   busy   : high while a window is being accumulated
//   valid  : one-cycle pulse on the edge that updates VALUE
//   VALUE  : signed count per element, WINDOW_LOG2+2 bits wide
//
// Timing
//   The edge that accepts start clears the accumulators and does not sample
//   Y. The next N edges each add one sample. The Nth of those edges loads
//   VALUE, including that last sample, and pulses valid. The block is then
//   idle again, so a start held high during the valid cycle begins the next
//   window straight away.
// ---------------------------------------------------------------------------
module stoch_signed_decode_mat #(
  parameter int NUM_ROWS    = 2,
  parameter int NUM_COLS    = 2,
  parameter int WINDOW_LOG2 = 4
) (
  input  logic                                                  CLK,
  input  logic                                                  nRST,
  input  logic                                                  start,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                     Y_p,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                     Y_m,
  output logic                                                  busy,
  output logic                                                  valid,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0][WINDOW_LOG2+1:0]    VALUE
);

  // W bits can hold both +N and -N, so the sum can never overflow.
  localparam int W = WINDOW_LOG2 + 2;

  // The counter holds this value during the last sample of a window.
  localparam logic [WINDOW_LOG2-1:0] CNT_LAST = {WINDOW_LOG2{1'b1}};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t                                         state_r;
  state_t                                         state_nxt_s;
  logic                                           clear_s;
  logic                                           acc_en_s;
  logic                                           done_s;
  logic [WINDOW_LOG2-1:0]                         cnt_r;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][W-1:0]       acc_r;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][W-1:0]       sum_s;
  logic                                           busy_r;
  logic                                           valid_r;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][W-1:0]       value_r;

  // Maps one rail pair to its signed step: +1, -1 or 0.
  function automatic logic [W-1:0] rail_delta(input logic p, input logic m);
    logic [W-1:0] d;
    case ({p, m})
      2'b10:   d = {{(W-1){1'b0}}, 1'b1};
      2'b01:   d = {W{1'b1}};
      default: d = {W{1'b0}};
    endcase
    return d;
  endfunction

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_nxt_s = state_r;
    clear_s     = 1'b0;
    acc_en_s    = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = ACCUM;
          clear_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCUM: begin
        acc_en_s = 1'b1;
        if (cnt_r == CNT_LAST) begin
          done_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Running sum plus the current sample. The rails are masked by acc_en_s,
  // so unknown rail values seen while idle never reach the accumulators.
  always_comb begin
    sum_s = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        sum_s[r][c] = acc_r[r][c] + rail_delta(Y_p[r][c] & acc_en_s,
                                               Y_m[r][c] & acc_en_s);
      end
    end
  end

  // Window counter and per-element accumulators. The counter wraps to zero
  // by itself on the last sample of a window.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_r <= {WINDOW_LOG2{1'b0}};
      acc_r <= '0;
    end else if (clear_s) begin
      cnt_r <= {WINDOW_LOG2{1'b0}};
      acc_r <= '0;
    end else if (acc_en_s) begin
      cnt_r <= cnt_r + {{(WINDOW_LOG2-1){1'b0}}, 1'b1};
      acc_r <= sum_s;
    end else begin
      cnt_r <= cnt_r;
      acc_r <= acc_r;
    end
  end

  // Registered outputs. VALUE captures the sum including the final sample.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      value_r <= '0;
    end else begin
      busy_r  <= (state_nxt_s == ACCUM);
      valid_r <= done_s;
      if (done_s) begin
        value_r <= sum_s;
      end else begin
        value_r <= value_r;
      end
    end
  end

  assign busy  = busy_r;
  assign valid = valid_r;
  assign VALUE = value_r;

endmodule

// File: tb/tb_stoch_signed_decode_mat.sv
// ---------------------------------------------------------------------------
// Testbench for stoch_signed_decode_mat (2x2 matrix, N = 16, 6-bit counts).
//
// A behavioural model tracks whether a window is open, how many samples it
// has taken, and the integer sum of (p - m) per element. The DUT outputs are
// compared against this model on every falling edge. Directed scenarios run
// first, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_stoch_signed_decode_mat;

  localparam int R  = 2;
  localparam int C  = 2;
  localparam int WL = 4;
  localparam int N  = 1 << WL;

  logic                          CLK;
  logic                          nRST;
  logic                          start;
  logic [R-1:0][C-1:0]           Y_p;
  logic [R-1:0][C-1:0]           Y_m;
  logic                          busy;
  logic                          valid;
  logic [R-1:0][C-1:0][WL+1:0]   VALUE;

  stoch_signed_decode_mat #(
    .NUM_ROWS   (R),
    .NUM_COLS   (C),
    .WINDOW_LOG2(WL)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .start(start),
    .Y_p  (Y_p),
    .Y_m  (Y_m),
    .busy (busy),
    .valid(valid),
    .VALUE(VALUE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  bit m_open;
  int m_taken;
  int m_sum [R][C];
  int m_val [R][C];
  bit m_valid;
  bit m_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic model_reset();
    m_open  = 1'b0;
    m_taken = 0;
    m_valid = 1'b0;
    m_busy  = 1'b0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        m_sum[r][c] = 0;
        m_val[r][c] = 0;
      end
  endtask

  // Updates the model for one rising edge, using the inputs as currently driven.
  task automatic model_edge();
    if (!nRST) begin
      model_reset();
    end else begin
      m_valid = 1'b0;
      if (!m_open) begin
        if (start) begin
          m_open  = 1'b1;
          m_taken = 0;
          for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) m_sum[r][c] = 0;
        end
      end else begin
        for (int r = 0; r < R; r++)
          for (int c = 0; c < C; c++)
            m_sum[r][c] += int'(Y_p[r][c]) - int'(Y_m[r][c]);
        m_taken++;
        if (m_taken == N) begin
          for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) m_val[r][c] = m_sum[r][c];
          m_valid = 1'b1;
          m_open  = 1'b0;
        end
      end
      m_busy = m_open;
    end
  endtask

  task automatic compare_all(input string where);
    logic [WL+1:0] ev;
    chk({where, ".busy"}, {31'd0, busy}, {31'd0, m_busy});
    chk({where, ".valid"}, {31'd0, valid}, {31'd0, m_valid});
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        ev = m_val[r][c][WL+1:0];
        chk($sformatf("%s.VALUE[%0d][%0d]", where, r, c), {26'd0, VALUE[r][c]}, {26'd0, ev});
      end
  endtask

  // One clock cycle: apply the model edge, let the DUT clock, then compare at the falling edge.
  task automatic tick(input string where);
    model_edge();
    @(posedge CLK);
    @(negedge CLK);
    compare_all(where);
  endtask

  int lat;
  int busy_cnt;
  int pulses;
  logic [WL+1:0] v00;

  initial begin
    nRST  = 1'b0;
    start = 1'b0;
    Y_p   = 4'($urandom);
    Y_m   = 4'($urandom);
    model_reset();

    // Reset check.
    for (int i = 0; i < 3; i++) begin
      Y_p = 4'($urandom);
      Y_m = 4'($urandom);
      tick("rst");
    end
    @(negedge CLK);
    nRST = 1'b1;
    compare_all("rst_rel");
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      Y_p = 4'($urandom);
      Y_m = 4'($urandom);
      tick("idle40");
      pulses += int'(valid);
    end
    chk("idle_pulses", pulses, 0);

    // Constant streams: [0][0]=+1, [0][1]=-1, [1][0]=p&m, [1][1]=none.
    // Element [r][c] sits at bit r*C+c of the packed rail vector.
    start = 1'b1;
    Y_p   = 4'b0101;
    Y_m   = 4'b0110;
    lat = 0;
    busy_cnt = 0;
    do begin
      tick("const");
      start = 1'b0;
      lat++;
      busy_cnt += int'(busy);
    end while (!valid && lat < 40);
    chk("const_latency", lat, 17);
    chk("const_busy_cycles", busy_cnt, 16);
    chk("const_v00", {26'd0, VALUE[0][0]}, 32'd16);
    chk("const_v01", {26'd0, VALUE[0][1]}, 32'b110000);
    chk("const_v10", {26'd0, VALUE[1][0]}, 32'd0);
    chk("const_v11", {26'd0, VALUE[1][1]}, 32'd0);
    tick("const_after");

    // Mixed stream on [0][0]: p = 1100..., m = 1000... gives +4.
    start = 1'b1;
    Y_p = 4'b0000;
    Y_m = 4'b0000;
    tick("mix_start");
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      Y_p = {3'($urandom), ((i % 4) < 2) ? 1'b1 : 1'b0};
      Y_m = {3'($urandom), ((i % 4) == 0) ? 1'b1 : 1'b0};
      tick("mix");
    end
    v00 = 6'd4;
    chk("mix_valid", {31'd0, valid}, 32'd1);
    chk("mix_v00", {26'd0, VALUE[0][0]}, {26'd0, v00});
    for (int i = 0; i < 10; i++) begin
      Y_p = 4'($urandom);
      Y_m = 4'($urandom);
      tick("mix_hold");
    end
    chk("mix_held_v00", {26'd0, VALUE[0][0]}, {26'd0, v00});

    // start pulses during an active window are ignored.
    start = 1'b1;
    tick("ign_start");
    start = 1'b0;
    pulses = 0;
    lat = 1;
    for (int i = 1; i <= N + 3; i++) begin
      start = (i == 3 || i == 9) ? 1'b1 : 1'b0;
      Y_p = 4'($urandom);
      Y_m = 4'($urandom);
      tick("ign");
      if (valid) begin
        pulses++;
        lat = i + 1;
      end
    end
    start = 1'b0;
    chk("ign_pulses", pulses, 1);
    chk("ign_latency", lat, 17);

    // start held high with p = 1 everywhere: back-to-back windows.
    start = 1'b1;
    Y_p = 4'b1111;
    Y_m = 4'b0000;
    pulses = 0;
    busy_cnt = 0;
    for (int i = 0; i < 3 * 17; i++) begin
      tick("b2b");
      pulses += int'(valid);
      busy_cnt += int'(!busy);
      if (valid) chk("b2b_v11", {26'd0, VALUE[1][1]}, 32'd16);
    end
    chk("b2b_pulses", pulses, 3);
    chk("b2b_busy_low", busy_cnt, 3);
    start = 1'b0;
    tick("b2b_end");

    // Reset in the middle of a window, then a clean window.
    start = 1'b1;
    tick("mrst_start");
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      Y_p = 4'($urandom);
      Y_m = 4'($urandom);
      tick("mrst_pre");
    end
    nRST = 1'b0;
    #1;
    model_reset();
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_valid", {31'd0, valid}, 32'd0);
    chk("mrst_value", {8'd0, VALUE}, 32'd0);
    tick("mrst_low");
    @(negedge CLK);
    nRST = 1'b1;
    tick("mrst_rel");
    start = 1'b1;
    tick("mrst_fresh");
    start = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      Y_p = 4'($urandom);
      Y_m = 4'($urandom);
      tick("mrst_run");
    end

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 7) == 0);
      Y_p = 4'($urandom);
      Y_m = 4'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        nRST = 1'b0;
        #1;
        model_reset();
        compare_all("rnd_async");
        tick("rnd_rst");
        @(negedge CLK);
        nRST = 1'b1;
      end
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
